// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared widths, default multiplier latency and the in-flight multiply tag type
// for the hazard scoreboard.
package hazard_pkg;

   localparam int REG_ADDR_W      = 5;
   localparam int MUL_LAT_DEFAULT = 3;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
   } mul_slot_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Decode/execute/memory hazard inputs and stall/multiplier-writeback outputs of
// the hazard scoreboard, bundled with master (pipeline) and slave (scoreboard) views.
interface hazard_scoreboard_unit_if
   import hazard_pkg::*;
#(
   parameter int DATA_WIDTH = REG_ADDR_W
);
   logic [DATA_WIDTH-1:0] D_Rs1;
   logic [DATA_WIDTH-1:0] D_Rs2;
   logic                  D_UseRs1;
   logic                  D_UseRs2;
   logic                  D_Branch;
   logic [DATA_WIDTH-1:0] E_Rd;
   logic                  E_RegWrite;
   logic                  E_MemRead;
   logic                  E_MulIssue;
   logic [DATA_WIDTH-1:0] M_Rd;
   logic                  M_MemRead;
   logic                  Stall_F;
   logic                  Stall_D;
   logic                  Flush_E;
   logic                  W_RegMul;
   logic [DATA_WIDTH-1:0] W_Rd_Mul;
   logic                  Mul_Busy;

   modport master (
      output D_Rs1, D_Rs2, D_UseRs1, D_UseRs2, D_Branch,
      output E_Rd, E_RegWrite, E_MemRead, E_MulIssue,
      output M_Rd, M_MemRead,
      input  Stall_F, Stall_D, Flush_E, W_RegMul, W_Rd_Mul, Mul_Busy
   );

   modport slave (
      input  D_Rs1, D_Rs2, D_UseRs1, D_UseRs2, D_Branch,
      input  E_Rd, E_RegWrite, E_MemRead, E_MulIssue,
      input  M_Rd, M_MemRead,
      output Stall_F, Stall_D, Flush_E, W_RegMul, W_Rd_Mul, Mul_Busy
   );

endinterface

// File: rtl/hazard_scoreboard_unit_mul_tag_pipe.sv
// Shift pipe of in-flight multiply tags: slot 0 captures the issuing multiply,
// every slot advances each cycle, and the last slot is the writeback cycle.
module mul_tag_pipe
   import hazard_pkg::*;
#(
   parameter int  LAT    = MUL_LAT_DEFAULT,
   parameter type slot_t = mul_slot_t
)(
   input  logic  clk,
   input  logic  reset,
   input  slot_t slot_i,
   output slot_t slots_o [LAT]
);

   slot_t slot_q [LAT];
   slot_t slot_d [LAT];

   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            assign slot_d[gi] = slot_i;
         end else begin : g_body
            assign slot_d[gi] = slot_q[gi-1];
         end
         assign slots_o[gi] = slot_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LAT; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LAT; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard: multiply-in-flight, load-use and optional decode-branch
// stalls. Define BRANCH_DECODE_HAZARD_EN to enable the decode-branch checks.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int DATA_WIDTH = REG_ADDR_W,
   parameter int MUL_LAT    = MUL_LAT_DEFAULT
)(
   input logic                     clk,
   input logic                     reset,
   hazard_scoreboard_unit_if.slave hz
);

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] rd;
   } slot_t;

   slot_t                 issue_d;
   slot_t                 slots [MUL_LAT];
   logic [MUL_LAT-1:0]    slot_valid;
   logic [MUL_LAT-2:0]    slot_hit;
   logic                  mul_issue_hit;
   logic                  load_hit;
   logic                  branch_hit;
   logic                  stall;

   // x0 never matches, and an unused source never matches.
   function automatic logic src_hit(
      input logic [DATA_WIDTH-1:0] rd,
      input logic [DATA_WIDTH-1:0] rs1,
      input logic [DATA_WIDTH-1:0] rs2,
      input logic                  use1,
      input logic                  use2
   );
      src_hit = (rd != '0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
   endfunction

   always_comb begin
      issue_d = '0;
      if (hz.E_MulIssue && hz.E_Rd != '0) begin
         issue_d.valid = 1'b1;
         issue_d.rd    = hz.E_Rd;
      end
   end

   mul_tag_pipe #(
      .LAT    (MUL_LAT),
      .slot_t (slot_t)
   ) u_mul_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .slot_i  (issue_d),
      .slots_o (slots)
   );

   genvar gi;
   generate
      for (gi = 0; gi < MUL_LAT; gi++) begin : g_valid
         assign slot_valid[gi] = slots[gi].valid;
      end
      // The last slot is the writeback cycle and is forwarded, so it never stalls.
      for (gi = 0; gi < MUL_LAT - 1; gi++) begin : g_hit
         assign slot_hit[gi] = slots[gi].valid &&
                               src_hit(slots[gi].rd, hz.D_Rs1, hz.D_Rs2,
                                       hz.D_UseRs1, hz.D_UseRs2);
      end
   endgenerate

   // An issue cannot take effect while reset is held, so it does not stall then.
   assign mul_issue_hit = reset && issue_d.valid &&
                          src_hit(issue_d.rd, hz.D_Rs1, hz.D_Rs2,
                                  hz.D_UseRs1, hz.D_UseRs2);

   assign load_hit = hz.E_MemRead &&
                     src_hit(hz.E_Rd, hz.D_Rs1, hz.D_Rs2, hz.D_UseRs1, hz.D_UseRs2);

`ifdef BRANCH_DECODE_HAZARD_EN
   assign branch_hit = hz.D_Branch &&
                       ((hz.E_RegWrite &&
                         src_hit(hz.E_Rd, hz.D_Rs1, hz.D_Rs2, hz.D_UseRs1, hz.D_UseRs2)) ||
                        (hz.M_MemRead &&
                         src_hit(hz.M_Rd, hz.D_Rs1, hz.D_Rs2, hz.D_UseRs1, hz.D_UseRs2)));
`else
   logic unused_branch_inputs;
   assign unused_branch_inputs = ^{hz.D_Branch, hz.E_RegWrite, hz.M_MemRead, hz.M_Rd};
   assign branch_hit = 1'b0;
`endif

   assign stall = mul_issue_hit || (|slot_hit) || load_hit || branch_hit;

   assign hz.Stall_F  = stall;
   assign hz.Stall_D  = stall;
   assign hz.Flush_E  = stall;
   assign hz.W_RegMul = slots[MUL_LAT-1].valid;
   assign hz.W_Rd_Mul = slots[MUL_LAT-1].rd;
   assign hz.Mul_Busy = |slot_valid;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with hand-computed expectations
// (MUL_LAT=3, 5-bit register addresses).
module tb_hazard_scoreboard_unit;
   import hazard_pkg::*;

   localparam int DW = 5;
   localparam int ML = 3;
`ifdef BRANCH_DECODE_HAZARD_EN
   localparam logic BR_EXP = 1'b1;
`else
   localparam logic BR_EXP = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   hazard_scoreboard_unit_if #(.DATA_WIDTH(DW)) hz();

   hazard_scoreboard_unit #(
      .DATA_WIDTH (DW),
      .MUL_LAT    (ML)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   task automatic check_outs(input string tag, input logic st, input logic busy,
                             input logic wreg, input logic [DW-1:0] wrd);
      check_eq({tag, ".stall_f"}, 32'(hz.Stall_F), 32'(st));
      check_eq({tag, ".stall_d"}, 32'(hz.Stall_D), 32'(st));
      check_eq({tag, ".flush_e"}, 32'(hz.Flush_E), 32'(st));
      check_eq({tag, ".busy"},    32'(hz.Mul_Busy), 32'(busy));
      check_eq({tag, ".wreg"},    32'(hz.W_RegMul), 32'(wreg));
      check_eq({tag, ".wrd"},     32'(hz.W_Rd_Mul), 32'(wrd));
   endtask

   task automatic clear_inputs();
      hz.D_Rs1      = '0;
      hz.D_Rs2      = '0;
      hz.D_UseRs1   = 1'b0;
      hz.D_UseRs2   = 1'b0;
      hz.D_Branch   = 1'b0;
      hz.E_Rd       = '0;
      hz.E_RegWrite = 1'b0;
      hz.E_MemRead  = 1'b0;
      hz.E_MulIssue = 1'b0;
      hz.M_Rd       = '0;
      hz.M_MemRead  = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic st_tab   [5];
      logic busy_tab [5];
      logic wreg_tab [5];
      logic [DW-1:0] wrd_tab [5];

      // Reset state and reset-time stall behaviour
      reset = 1'b0;
      clear_inputs();
      #2;
      check_outs("rst_idle", 1'b0, 1'b0, 1'b0, 5'd0);
      hz.E_MemRead = 1'b1; hz.E_Rd = 5'd7; hz.D_Rs1 = 5'd7; hz.D_UseRs1 = 1'b1;
      #1;
      check_eq("rst_load.stall", 32'(hz.Stall_D), 32'd1);
      clear_inputs();
      hz.E_MulIssue = 1'b1; hz.E_Rd = 5'd5; hz.D_Rs1 = 5'd5; hz.D_UseRs1 = 1'b1;
      #1;
      check_eq("rst_mulissue.stall", 32'(hz.Stall_D), 32'd0);
      clear_inputs();
      @(negedge clk);
      reset = 1'b1;

      // Multiply to x5, decode reading x5 throughout
      st_tab   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      busy_tab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      wreg_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      wrd_tab  = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd0};
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         clear_inputs();
         hz.D_Rs1 = 5'd5; hz.D_UseRs1 = 1'b1;
         if (k == 0) begin
            hz.E_MulIssue = 1'b1; hz.E_Rd = 5'd5;
         end
         @(negedge clk);
         check_outs($sformatf("mul_x5.c%0d", k), st_tab[k], busy_tab[k], wreg_tab[k], wrd_tab[k]);
      end

      // Load-use
      next_cycle();
      clear_inputs();
      hz.E_MemRead = 1'b1; hz.E_Rd = 5'd7; hz.D_Rs2 = 5'd7; hz.D_UseRs2 = 1'b1;
      @(negedge clk);
      check_eq("load_x7.stall", 32'(hz.Stall_D), 32'd1);
      next_cycle();
      hz.E_MemRead = 1'b0; hz.E_Rd = 5'd0;
      @(negedge clk);
      check_eq("load_x7.bubble", 32'(hz.Stall_D), 32'd0);
      next_cycle();
      hz.E_MemRead = 1'b1; hz.E_Rd = 5'd0; hz.D_Rs2 = 5'd0;
      @(negedge clk);
      check_eq("load_x0.stall", 32'(hz.Stall_D), 32'd0);
      next_cycle();
      clear_inputs();
      hz.E_MemRead = 1'b1; hz.E_Rd = 5'd7; hz.D_Rs1 = 5'd7; hz.D_UseRs1 = 1'b0;
      @(negedge clk);
      check_eq("load_unused_src.stall", 32'(hz.Stall_D), 32'd0);

      // Decode branch hazards
      next_cycle();
      clear_inputs();
      hz.D_Branch = 1'b1; hz.D_Rs1 = 5'd3; hz.D_UseRs1 = 1'b1;
      hz.E_RegWrite = 1'b1; hz.E_Rd = 5'd3;
      @(negedge clk);
      check_eq("br_alu_x3.stall", 32'(hz.Stall_D), 32'(BR_EXP));
      next_cycle();
      hz.E_RegWrite = 1'b0; hz.E_Rd = 5'd0;
      hz.M_MemRead = 1'b1; hz.M_Rd = 5'd3;
      @(negedge clk);
      check_eq("br_mload_x3.stall", 32'(hz.Stall_D), 32'(BR_EXP));
      next_cycle();
      clear_inputs();
      hz.D_Rs1 = 5'd3; hz.D_UseRs1 = 1'b1; hz.E_RegWrite = 1'b1; hz.E_Rd = 5'd3;
      @(negedge clk);
      check_eq("nobr_alu_x3.stall", 32'(hz.Stall_D), 32'd0);
      next_cycle();
      clear_inputs();
      hz.D_Branch = 1'b1; hz.D_UseRs1 = 1'b1; hz.E_RegWrite = 1'b1;
      @(negedge clk);
      check_eq("br_x0.stall", 32'(hz.Stall_D), 32'd0);

      // Back-to-back multiplies to x1, x2, x3
      for (int k = 0; k < 7; k++) begin
         logic          e_st;
         logic          e_busy;
         logic          e_wreg;
         logic [DW-1:0] e_wrd;
         next_cycle();
         clear_inputs();
         if (k < 3) begin
            hz.E_MulIssue = 1'b1; hz.E_Rd = 5'(k + 1);
         end
         if (k == 3) begin
            hz.D_Rs1 = 5'd1; hz.D_UseRs1 = 1'b1;
         end
         if (k == 4) begin
            hz.D_Rs1 = 5'd2; hz.D_UseRs1 = 1'b1; hz.D_Rs2 = 5'd3; hz.D_UseRs2 = 1'b1;
         end
         if (k == 5) begin
            hz.D_Rs1 = 5'd3; hz.D_UseRs1 = 1'b1;
         end
         e_st   = (k == 4);
         e_busy = (k >= 1 && k <= 5);
         e_wreg = (k >= 3 && k <= 5);
         e_wrd  = e_wreg ? 5'(k - 2) : 5'd0;
         @(negedge clk);
         check_outs($sformatf("b2b.c%0d", k), e_st, e_busy, e_wreg, e_wrd);
      end

      // Reset pulsed one cycle after a multiply issue
      next_cycle();
      clear_inputs();
      hz.E_MulIssue = 1'b1; hz.E_Rd = 5'd6; hz.D_Rs1 = 5'd6; hz.D_UseRs1 = 1'b1;
      @(negedge clk);
      check_outs("rstmid.issue", 1'b1, 1'b0, 1'b0, 5'd0);
      next_cycle();
      hz.E_MulIssue = 1'b0; hz.E_Rd = 5'd0;
      check_outs("rstmid.inflight", 1'b1, 1'b1, 1'b0, 5'd0);
      reset = 1'b0;
      #1;
      check_outs("rstmid.asserted", 1'b0, 1'b0, 1'b0, 5'd0);
      next_cycle();
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_outs($sformatf("rstmid.after%0d", k), 1'b0, 1'b0, 1'b0, 5'd0);
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
